// File: rtl/bip_program_loader.sv
// Packs UART bytes into 16-bit BIP instruction words and writes them to program memory.
// Optional trailing checksum byte is enabled with LOADER_CHECKSUM_EN.
module bip_program_loader #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int OPCODE_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              bip_reset,
  output logic              load_busy,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_overflow,
  output logic              err_checksum
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_HI, S_WAIT_LO, S_WRITE, S_DONE, S_CHECK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_HI, S_WAIT_LO, S_WRITE, S_DONE
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          hi_q, hi_d;
  logic [ADDR_W-1:0]   prog_addr_q, prog_addr_d;
  logic [DATA_W-1:0]   prog_data_q, prog_data_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                err_overflow_q, err_overflow_d;
  logic                halt_word;
  logic                last_addr;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
  logic                err_checksum_q, err_checksum_d;
`endif

  assign halt_word = (prog_data_q[DATA_W-1 -: OPCODE_W] == '0);
  assign last_addr = (addr_q == ADDR_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      hi_q           <= '0;
      prog_addr_q    <= '0;
      prog_data_q    <= '0;
      word_count_q   <= '0;
      err_overflow_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q          <= '0;
      err_checksum_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      hi_q           <= hi_d;
      prog_addr_q    <= prog_addr_d;
      prog_data_q    <= prog_data_d;
      word_count_q   <= word_count_d;
      err_overflow_q <= err_overflow_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q          <= sum_d;
      err_checksum_q <= err_checksum_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    hi_d           = hi_q;
    prog_addr_d    = prog_addr_q;
    prog_data_d    = prog_data_q;
    word_count_d   = word_count_q;
    err_overflow_d = err_overflow_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d          = sum_q;
    err_checksum_d = err_checksum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d        = S_WAIT_HI;
          addr_d         = '0;
          word_count_d   = '0;
          err_overflow_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          sum_d          = '0;
          err_checksum_d = 1'b0;
`endif
        end
      end
      S_WAIT_HI: begin
        if (rx_done) begin
          hi_d    = rx_data;
          state_d = S_WAIT_LO;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data;
`endif
        end
      end
      S_WAIT_LO: begin
        if (rx_done) begin
          prog_data_d = {hi_q, rx_data};
          prog_addr_d = addr_q;
          state_d     = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_q + rx_data;
`endif
        end
      end
      S_WRITE: begin
        // Address parks at the top entry so it can never wrap back to 0.
        if (!last_addr) addr_d = addr_q + 1'b1;
        if (word_count_q != DEPTH) word_count_d = word_count_q + 1'b1;
        if (halt_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else if (last_addr) begin
          err_overflow_d = 1'b1;
          state_d        = S_DONE;
        end else if (rx_done) begin
          hi_d    = rx_data;
          state_d = S_WAIT_LO;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data;
`endif
        end else begin
          state_d = S_WAIT_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_done) begin
          err_checksum_d = (rx_data != sum_q);
          state_d        = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign prog_we      = (state_q == S_WRITE);
  assign prog_addr    = prog_addr_q;
  assign prog_data    = prog_data_q;
`ifdef LOADER_CHECKSUM_EN
  assign load_busy    = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO) ||
                        (state_q == S_WRITE)   || (state_q == S_CHECK);
  assign err_checksum = err_checksum_q;
`else
  assign load_busy    = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO) ||
                        (state_q == S_WRITE);
  assign err_checksum = 1'b0;
`endif
  assign bip_reset    = load_busy;
  assign load_done    = (state_q == S_DONE);
  assign word_count   = word_count_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_bip_program_loader.sv
// Bench for bip_program_loader: a full-size and a 4-word instance share stimulus,
// each checked every cycle against a byte-stream model of the load.
module tb_bip_program_loader;
  localparam int AW  = 11;
  localparam int AWS = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0;
  logic rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;

  logic          prog_we_b, bip_reset_b, load_busy_b, load_done_b, err_overflow_b, err_checksum_b;
  logic [AW-1:0] prog_addr_b;
  logic [15:0]   prog_data_b;
  logic [AW:0]   word_count_b;

  logic           prog_we_s, bip_reset_s, load_busy_s, load_done_s, err_overflow_s, err_checksum_s;
  logic [AWS-1:0] prog_addr_s;
  logic [15:0]    prog_data_s;
  logic [AWS:0]   word_count_s;

  int tests = 0;
  int fails = 0;
  logic [31:0] log_b[$];
  logic [31:0] log_s[$];

  bip_program_loader #(.ADDR_W(AW)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_done(rx_done),
    .prog_we(prog_we_b), .prog_addr(prog_addr_b), .prog_data(prog_data_b),
    .bip_reset(bip_reset_b), .load_busy(load_busy_b), .load_done(load_done_b),
    .word_count(word_count_b), .err_overflow(err_overflow_b), .err_checksum(err_checksum_b));

  bip_program_loader #(.ADDR_W(AWS)) dut_s (
    .clk(clk), .reset_n(reset_n), .start(start), .rx_data(rx_data), .rx_done(rx_done),
    .prog_we(prog_we_s), .prog_addr(prog_addr_s), .prog_data(prog_data_s),
    .bip_reset(bip_reset_s), .load_busy(load_busy_s), .load_done(load_done_s),
    .word_count(word_count_s), .err_overflow(err_overflow_s), .err_checksum(err_checksum_s));

  always #5 clk = ~clk;

  // Load seen as a byte stream: pairs of bytes become words at address = words so far.
  typedef struct {
    bit          active;
    bit          done;
    bit          have_hi;
    bit          wr;
    bit          ovf;
    bit          cwait;
    bit          cerr;
    logic [7:0]  hi;
    logic [7:0]  sum;
    int          words;
    int          waddr;
    logic [15:0] wdata;
  } mdl_t;

  mdl_t m_b, m_s;

  task automatic model_step(inout mdl_t m, input int depth);
    if (m.wr) begin
      m.wr = 0;
      m.words++;
      if (m.wdata[15:11] == 5'd0) begin
`ifdef LOADER_CHECKSUM_EN
        m.cwait = 1;
`else
        m.active = 0;
        m.done = 1;
`endif
      end else if (m.words == depth) begin
        m.ovf = 1;
        m.active = 0;
        m.done = 1;
      end else if (rx_done) begin
        m.hi = rx_data;
        m.have_hi = 1;
        m.sum = m.sum + rx_data;
      end
    end else if (m.cwait) begin
      if (rx_done) begin
        m.cerr = (rx_data != m.sum);
        m.cwait = 0;
        m.active = 0;
        m.done = 1;
      end
    end else if (m.active) begin
      if (rx_done) begin
        m.sum = m.sum + rx_data;
        if (!m.have_hi) begin
          m.hi = rx_data;
          m.have_hi = 1;
        end else begin
          m.wr = 1;
          m.waddr = m.words;
          m.wdata = {m.hi, rx_data};
          m.have_hi = 0;
        end
      end
    end else if (start) begin
      m.active = 1;
      m.done = 0;
      m.words = 0;
      m.ovf = 0;
      m.cerr = 0;
      m.have_hi = 0;
      m.sum = 8'h00;
    end
  endtask

  initial begin
    m_b = '{default: 0};
    m_s = '{default: 0};
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_b = '{default: 0};
      m_s = '{default: 0};
    end else begin
      model_step(m_b, 1 << AW);
      model_step(m_s, 1 << AWS);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string t, input mdl_t m, input logic we, input logic [31:0] addr,
                         input logic [15:0] data, input logic busy, input logic bres,
                         input logic done, input logic [31:0] wc, input logic ovf,
                         input logic cerr);
    chk({t, ".prog_we"}, {31'd0, we}, {31'd0, m.wr});
    if (m.wr) begin
      chk({t, ".prog_addr"}, addr, m.waddr);
      chk({t, ".prog_data"}, {16'd0, data}, {16'd0, m.wdata});
    end
    chk({t, ".load_busy"}, {31'd0, busy}, {31'd0, m.active});
    chk({t, ".bip_reset"}, {31'd0, bres}, {31'd0, m.active});
    chk({t, ".load_done"}, {31'd0, done}, {31'd0, m.done});
    chk({t, ".word_count"}, wc, m.words);
    chk({t, ".err_overflow"}, {31'd0, ovf}, {31'd0, m.ovf});
    chk({t, ".err_checksum"}, {31'd0, cerr}, {31'd0, m.cerr});
  endtask

  always @(negedge clk) begin
    cmp_dut("big", m_b, prog_we_b, {21'd0, prog_addr_b}, prog_data_b, load_busy_b, bip_reset_b,
            load_done_b, {20'd0, word_count_b}, err_overflow_b, err_checksum_b);
    cmp_dut("small", m_s, prog_we_s, {30'd0, prog_addr_s}, prog_data_s, load_busy_s, bip_reset_s,
            load_done_s, {29'd0, word_count_s}, err_overflow_s, err_checksum_s);
    if (prog_we_b) log_b.push_back({5'd0, prog_addr_b, prog_data_b});
    if (prog_we_s) log_s.push_back({14'd0, prog_addr_s, prog_data_s});
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle(gap);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    logic [15:0] tmp;
    tmp = w;
    send_byte(tmp[15:8], gap);
    send_byte(tmp[7:0], gap);
  endtask

  task automatic wait_done_b(input string nm);
    int k;
    k = 0;
    while (!load_done_b && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({nm, ".done_in_time"}, {31'd0, load_done_b}, 32'd1);
  endtask

  task automatic clear_logs();
    log_b.delete();
    log_s.delete();
  endtask

  initial begin
    logic [7:0] sum;
    int nw;
    logic [15:0] w;

    #2 reset_n = 1'b0;
    idle(2);
    chk("reset.prog_we", {31'd0, prog_we_b}, 32'd0);
    chk("reset.prog_addr", {21'd0, prog_addr_b}, 32'd0);
    chk("reset.prog_data", {16'd0, prog_data_b}, 32'd0);
    chk("reset.word_count", {20'd0, word_count_b}, 32'd0);
    chk("reset.load_busy", {31'd0, load_busy_b}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Bytes before start are ignored.
    send_byte(8'hAA, 0);
    idle(2);
    chk("idle.no_write", log_b.size(), 32'd0);
    chk("idle.not_busy", {31'd0, load_busy_b}, 32'd0);

    // Three-word program with a start pulse mid-load that must be ignored.
    pulse_start();
    send_word(16'h1805, 1);
    idle(2);
    pulse_start();
    chk("ignore_start.word_count", {20'd0, word_count_b}, 32'd1);
    send_word(16'h0810, 0);
    send_word(16'h0000, 2);
`ifdef LOADER_CHECKSUM_EN
    chk("t1.not_done_before_ck", {31'd0, load_done_b}, 32'd0);
    send_byte(8'h35, 1);
`endif
    wait_done_b("t1");
    chk("t1.nwrites", log_b.size(), 32'd3);
    if (log_b.size() == 3) begin
      chk("t1.w0", log_b[0], 32'h0000_1805);
      chk("t1.w1", log_b[1], 32'h0001_0810);
      chk("t1.w2", log_b[2], 32'h0002_0000);
    end
    chk("t1.word_count", {20'd0, word_count_b}, 32'd3);
    chk("t1.bip_reset", {31'd0, bip_reset_b}, 32'd0);
    chk("t1.err_overflow", {31'd0, err_overflow_b}, 32'd0);

    // Overflow on the 4-word instance.
    clear_logs();
    pulse_start();
    repeat (4) send_word(16'h2001, 1);
    idle(2);
    chk("ovf.err_overflow", {31'd0, err_overflow_s}, 32'd1);
    chk("ovf.load_done", {31'd0, load_done_s}, 32'd1);
    chk("ovf.word_count", {29'd0, word_count_s}, 32'd4);
    send_word(16'h2001, 1);
    idle(2);
    chk("ovf.nwrites", log_s.size(), 32'd4);
    for (int i = 0; i < 4 && i < log_s.size(); i++)
      chk("ovf.write", log_s[i], {14'd0, i[1:0], 16'h2001});
    send_word(16'h0000, 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 1);
`endif
    wait_done_b("ovf_big");

    // Back-to-back bytes, high byte of the next word arriving in the write cycle.
    clear_logs();
    pulse_start();
    send_word(16'h1805, 0);
    send_word(16'h2007, 0);
    send_word(16'h0000, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h44, 0);
`endif
    wait_done_b("b2b");
    chk("b2b.nwrites", log_b.size(), 32'd3);
    if (log_b.size() == 3) chk("b2b.w1", log_b[1], 32'h0001_2007);

    // Asynchronous reset in the middle of a load.
    clear_logs();
    pulse_start();
    send_byte(8'h18, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst.load_busy", {31'd0, load_busy_b}, 32'd0);
    chk("rst.bip_reset", {31'd0, bip_reset_b}, 32'd0);
    chk("rst.load_done", {31'd0, load_done_b}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(1);
    pulse_start();
    send_word(16'h3002, 1);
    send_word(16'h0000, 1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h32, 1);
`endif
    wait_done_b("rst");
    if (log_b.size() > 0) chk("rst.first_write", log_b[0], 32'h0000_3002);
    else chk("rst.nwrites", 32'd0, 32'd2);

`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    send_word(16'h1805, 1);
    send_word(16'h0000, 1);
    idle(3);
    chk("ck.not_done_before_ck", {31'd0, load_done_b}, 32'd0);
    send_byte(8'h1D, 1);
    wait_done_b("ck_good");
    chk("ck.good", {31'd0, err_checksum_b}, 32'd0);
    pulse_start();
    send_word(16'h1805, 1);
    send_word(16'h0000, 1);
    idle(3);
    chk("ck.not_done_before_ck2", {31'd0, load_done_b}, 32'd0);
    send_byte(8'h1E, 1);
    wait_done_b("ck_bad");
    chk("ck.bad", {31'd0, err_checksum_b}, 32'd1);
`endif

    // Randomised loads; the per-cycle compare checks both instances.
    for (int l = 0; l < 40; l++) begin
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), $urandom_range(0, 2));
      pulse_start();
      sum = 8'h00;
      nw = $urandom_range(1, 7);
      for (int k = 0; k < nw; k++) begin
        w = (k == nw - 1) ? {5'd0, 11'($urandom)} : {5'($urandom_range(1, 31)), 11'($urandom)};
        send_word(w, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 3));
        sum = sum + w[15:8] + w[7:0];
        if ($urandom_range(0, 7) == 0) pulse_start();
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(($urandom_range(0, 1) == 0) ? sum : 8'($urandom), $urandom_range(0, 2));
`endif
      wait_done_b("rand");
      idle($urandom_range(0, 3));
    end

    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
